// File: rtl/heat_bus_pkg.sv
// Shared types and constants for the heat-solver bus master.
package heat_bus_pkg;

  // Default grid size (cells per grid, also RUN cycles per iteration).
  localparam int CELLS_DEFAULT = 25;
  // Default length of a WRITE/READ bus phase in clock cycles.
  localparam int HOLD_DEFAULT  = 5;

  // Solver pin-protocol modes carried on ui_in[7:6].
  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_WR   = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  // Idle/no-op word driven on ui_in between phases.
  localparam logic [7:0] BUS_IDLE = {MODE_IDLE, 6'd0};

  // Host command opcodes; encoding 3 is reserved and rejected.
  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  // Master sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUNNING,
    ST_RESP,
    ST_GAP
  } state_e;

  // Counter width able to hold both the longest RUN phase and a hold phase.
  function automatic int cnt_width(input int iter_w, input int cells, input int hold);
    int run_max;
    run_max = ((1 << iter_w) - 1) * cells;
    return $clog2((run_max > hold) ? run_max : hold);
  endfunction

endpackage

// File: rtl/heat_bus_master_if.sv
// Host command/response handshake plus the solver pin bus, as one bundle.
interface heat_bus_master_if #(
  parameter int DATA_W = 4,
  parameter int ITER_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [5:0]        cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [ITER_W-1:0] cmd_iters;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic [7:0]        bus_ui;
  logic [7:0]        bus_uio;
  logic [7:0]        bus_rd;
  logic              busy;

  // Bus master side.
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_iters, rsp_ready, bus_rd,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, bus_ui, bus_uio, busy
  );

  // Host / solver side.
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_iters, rsp_ready, bus_rd,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, bus_ui, bus_uio, busy
  );

endinterface

// File: rtl/heat_bus_phase_cnt.sv
// Down-counter timing a bus phase: load remaining-cycles-minus-one, count to zero.
module heat_bus_phase_cnt #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load on accept, then decrement once per phase cycle and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/heat_bus_master.sv
// Host-side initiator that turns single-cycle WRITE/READ/RUN commands into
// correctly timed solver pin phases and returns one response per command.
module heat_bus_master
  import heat_bus_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_DEFAULT,
  parameter int CELLS       = CELLS_DEFAULT,
  parameter int ITER_W      = 8,
  parameter int DATA_W      = 4
) (
  input logic              clk,
  input logic              rst,
  heat_bus_master_if.master bus
);

  localparam int CNT_W = cnt_width(ITER_W, CELLS, HOLD_CYCLES);

  state_e            state_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              busy_q;
  logic              is_read_q;
  logic [7:0]        bus_ui_q;
  logic [7:0]        bus_uio_q;

  logic              accept;
  logic              addr_ok;
  logic              cnt_zero;
  logic              cnt_load;

  // Decoded view of the offered command (only acted upon when accepted).
  state_e            dec_next;
  logic              dec_err;
  logic              dec_read;
  logic [7:0]        dec_ui;
  logic [7:0]        dec_uio;
  logic [CNT_W-1:0]  dec_cnt;

  // Upper read-back pins carry nothing for us.
  logic rd_unused;
  assign rd_unused = ^bus.bus_rd[7:DATA_W];

  // cmd_ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept  = bus.cmd_valid && cmd_ready_q;
  assign addr_ok = 32'(bus.cmd_addr) < 32'(CELLS);
  assign cnt_load = accept && (dec_next != ST_RESP);

  // Decode the command into its bus word, phase length and follow-on state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dec_next = ST_RESP;
    dec_err  = 1'b1;
    dec_read = 1'b0;
    dec_ui   = BUS_IDLE;
    dec_uio  = 8'h00;
    dec_cnt  = '0;
    case (bus.cmd_op)
      OP_RUN: begin
        dec_err = 1'b0;
        if (bus.cmd_iters != '0) begin
          dec_next = ST_RUNNING;
          dec_ui   = {MODE_RUN, 6'd0};
          dec_cnt  = CNT_W'(bus.cmd_iters) * CNT_W'(CELLS) - CNT_W'(1);
        end
      end
      OP_WRITE: begin
        if (addr_ok) begin
          dec_next = ST_HOLD;
          dec_err  = 1'b0;
          dec_ui   = {MODE_WR, bus.cmd_addr};
          dec_uio  = 8'(bus.cmd_data);
          dec_cnt  = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      OP_READ: begin
        if (addr_ok) begin
          dec_next = ST_HOLD;
          dec_err  = 1'b0;
          dec_read = 1'b1;
          dec_ui   = {MODE_RD, bus.cmd_addr};
          dec_cnt  = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      default: ;
    endcase
  end

  heat_bus_phase_cnt #(
    .W (CNT_W)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (dec_cnt),
    .en_i       (busy_q),
    .zero_o     (cnt_zero)
  );

  // Sequencer: accept, drive the phase, present the response, then force one idle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      is_read_q   <= 1'b0;
      bus_ui_q    <= BUS_IDLE;
      bus_uio_q   <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= dec_err;
            is_read_q   <= dec_read;
            bus_ui_q    <= dec_ui;
            bus_uio_q   <= dec_uio;
            busy_q      <= (dec_next != ST_RESP);
            rsp_valid_q <= (dec_next == ST_RESP);
            state_q     <= dec_next;
          end
        end
        ST_HOLD, ST_RUNNING: begin
          if (cnt_zero) begin
            bus_ui_q    <= BUS_IDLE;
            bus_uio_q   <= 8'h00;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (is_read_q) begin
              rsp_data_q <= bus.bus_rd[DATA_W-1:0];
            end
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_GAP;
          end
        end
        ST_GAP: begin
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.bus_ui    = bus_ui_q;
  assign bus.bus_uio   = bus_uio_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_heat_bus_master.sv
// Self-checking bench for heat_bus_master: directed scenarios, then random
// commands scored against a command-level reference model and a solver model.
module tb_heat_bus_master;

  localparam int HOLD  = 5;
  localparam int NCELL = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference contents the host expects the solver to hold.
  logic [3:0] ref_mem [64];
  // Behavioural solver storage, written only through the pin protocol.
  logic [3:0] solver_mem [64];

  heat_bus_master_if #(.DATA_W(4), .ITER_W(8)) hif ();

  heat_bus_master #(
    .HOLD_CYCLES (HOLD),
    .CELLS       (NCELL),
    .ITER_W      (8),
    .DATA_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.master)
  );

  always #5 clk = ~clk;

  // Solver model: commit on write-mode edges, return the addressed cell in read mode.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) solver_mem[i] <= 4'h0;
    end else if (hif.bus_ui[7:6] == 2'b01) begin
      solver_mem[hif.bus_ui[5:0]] <= hif.bus_uio[3:0];
    end
  end
  assign hif.bus_rd = (hif.bus_ui[7:6] == 2'b10) ? {4'h0, solver_mem[hif.bus_ui[5:0]]} : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a command (starting at a negedge), hold it until accepted, then withdraw it.
  task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [3:0] data,
                       input logic [7:0] iters, output bit ok);
    hif.cmd_op    = op;
    hif.cmd_addr  = addr;
    hif.cmd_data  = data;
    hif.cmd_iters = iters;
    hif.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 40; w++) begin
      if (hif.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("cmd_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    hif.cmd_valid = 1'b0;
    hif.cmd_op    = 2'($urandom);
    hif.cmd_addr  = 6'($urandom);
    hif.cmd_data  = 4'($urandom);
    hif.cmd_iters = 8'($urandom);
  endtask

  // Run one command end to end; bp = cycles to withhold rsp_ready once the response is up.
  task automatic exec(input logic [1:0] op, input logic [5:0] addr, input logic [3:0] data,
                      input logic [7:0] iters, input int bp);
    logic       exp_err;
    int         exp_len;
    logic [7:0] exp_ui;
    logic [7:0] exp_uio;
    logic [3:0] exp_data;
    int         bad;
    int         rv_at;
    bit         ok;

    exp_ui   = 8'hC0;
    exp_uio  = 8'h00;
    exp_data = 4'h0;
    exp_len  = 0;
    exp_err  = (op == 2'd3) || ((op != 2'd0) && (addr >= 6'd25));
    if (op == 2'd0) begin
      exp_len = NCELL * int'(iters);
      exp_ui  = 8'h00;
    end else if (!exp_err) begin
      exp_len = HOLD;
      exp_ui  = {((op == 2'd1) ? 2'b01 : 2'b10), addr};
      if (op == 2'd1) exp_uio = {4'h0, data};
    end
    if ((op == 2'd2) && !exp_err) exp_data = ref_mem[addr];
    if ((op == 2'd1) && !exp_err) ref_mem[addr] = data;

    hif.rsp_ready = (bp == 0);
    issue(op, addr, data, iters, ok);

    // Bus must carry the phase word for exactly exp_len cycles, then the response appears.
    bad   = 0;
    rv_at = -1;
    for (int c = 1; c <= exp_len + 4; c++) begin
      @(negedge clk);
      if (hif.rsp_valid === 1'b1) begin
        rv_at = c;
        break;
      end
      if (hif.bus_ui !== exp_ui || hif.bus_uio !== exp_uio ||
          hif.busy !== 1'b1 || hif.cmd_ready !== 1'b0) bad++;
    end
    check("phase_bus", 32'(bad), 32'd0);
    check("rsp_latency", 32'(rv_at), 32'(exp_len + 1));
    check("rsp_bus_idle", {hif.bus_ui, hif.bus_uio, hif.busy, hif.cmd_ready},
          {8'hC0, 8'h00, 1'b0, 1'b0});
    check("rsp_data", 32'(hif.rsp_data), 32'(exp_data));
    check("rsp_err", 32'(hif.rsp_err), 32'(exp_err));

    bad = 0;
    for (int j = 0; j < bp; j++) begin
      @(negedge clk);
      if (hif.rsp_valid !== 1'b1 || hif.rsp_data !== exp_data || hif.rsp_err !== exp_err ||
          hif.cmd_ready !== 1'b0 || hif.bus_ui !== 8'hC0 || hif.busy !== 1'b0) bad++;
    end
    if (bp > 0) check("rsp_hold", 32'(bad), 32'd0);
    hif.rsp_ready = 1'b1;

    @(negedge clk);
    check("gap", {hif.rsp_valid, hif.rsp_err, hif.cmd_ready, hif.bus_ui},
          {1'b0, 1'b0, 1'b0, 8'hC0});
    if (bp > 0) begin
      @(negedge clk);
      check("ready_after_gap", 32'(hif.cmd_ready), 32'd1);
    end
  endtask

  initial begin
    bit         ok;
    int         seen;
    int         r;
    logic [1:0] op;
    logic [5:0] addr;
    logic [3:0] data;
    logic [7:0] iters;
    int         bp;

    for (int i = 0; i < 64; i++) ref_mem[i] = 4'h0;
    hif.cmd_valid = 1'b0;
    hif.cmd_op    = 2'd0;
    hif.cmd_addr  = 6'd0;
    hif.cmd_data  = 4'd0;
    hif.cmd_iters = 8'd0;
    hif.rsp_ready = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_bus", {hif.bus_ui, hif.bus_uio}, {8'hC0, 8'h00});
    check("reset_ctl", {hif.cmd_ready, hif.rsp_valid, hif.rsp_err, hif.busy, hif.rsp_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a RUN aborts it asynchronously with no response.
    issue(2'd0, 6'd0, 4'd0, 8'd3, ok);
    repeat (20) @(negedge clk);
    check("run_mid", {hif.bus_ui, hif.busy}, {8'h00, 1'b1});
    #3 rst = 1'b1;
    #1;
    check("async_reset", {hif.bus_ui, hif.busy, hif.rsp_valid, hif.cmd_ready},
          {8'hC0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 64; i++) ref_mem[i] = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (90) begin
      @(negedge clk);
      if (hif.rsp_valid !== 1'b0 || hif.bus_ui !== 8'hC0) seen++;
    end
    check("no_rsp_after_reset", 32'(seen), 32'd0);

    // Directed scenarios.
    exec(2'd1, 6'd12, 4'd10, 8'd0, 0);   // WRITE 12 = 10
    exec(2'd2, 6'd12, 4'd0,  8'd0, 0);   // READ 12
    exec(2'd0, 6'd0,  4'd0,  8'd3, 0);   // RUN 3 iterations
    exec(2'd1, 6'd25, 4'd5,  8'd0, 0);   // WRITE out of range
    exec(2'd2, 6'd63, 4'd0,  8'd0, 0);   // READ out of range
    exec(2'd3, 6'd4,  4'd0,  8'd0, 0);   // reserved op
    exec(2'd0, 6'd0,  4'd0,  8'd0, 0);   // RUN 0 iterations
    exec(2'd1, 6'd7,  4'd9,  8'd0, 0);
    exec(2'd2, 6'd7,  4'd0,  8'd0, 10);  // READ under backpressure
    exec(2'd1, 6'd13, 4'd12, 8'd0, 0);   // back-to-back WRITE/READ
    exec(2'd2, 6'd13, 4'd0,  8'd0, 0);
    exec(2'd1, 6'd24, 4'd15, 8'd0, 0);   // highest legal address
    exec(2'd2, 6'd24, 4'd0,  8'd0, 0);
    exec(2'd2, 6'd0,  4'd0,  8'd0, 0);   // never-written cell

    // Random traffic scored against the reference model.
    for (int n = 0; n < 40; n++) begin
      r     = int'($urandom_range(0, 9));
      op    = (r < 3) ? 2'd2 : (r < 6) ? 2'd1 : (r < 8) ? 2'd0 : 2'd3;
      addr  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(25, 63)) : 6'($urandom_range(0, 24));
      data  = 4'($urandom);
      iters = 8'($urandom_range(0, 3));
      bp    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      exec(op, addr, data, iters, bp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
